block_tiler: RTL and testbench
==============================

// Module: block_tiler
// PURPOSE
//   Streaming raster-to-block converter that feeds the 2-D DCT (dct2d). It accepts an
//   IMG_H x IMG_W image one signed pixel per cycle in raster order, then emits BLK x BLK
//   tiles as flat vectors in block-raster order, each tagged with its block coordinates.
//   Two band buffers (ping-pong) let one band fill while the other drains.
// PARAMETERS
//   N      16   pixel width in bits (signed, two's complement)
//   IMG_W  128  image width in pixels; must be a multiple of BLK
//   IMG_H  128  image height in pixels; must be a multiple of BLK
//   BLK    8    tile edge; one tile is BLK*BLK pixels
// PORTS
//   clk        in   1              clock, all logic on posedge
//   rst        in   1              synchronous active-high reset
//   pix_in     in   N              input pixel, signed
//   pix_valid  in   1              pix_in valid
//   pix_ready  out  1              tiler can accept pix_in this cycle
//   blk_out    out  N*BLK*BLK      tile; element (r,c) at [((r*BLK+c)*N) +: N]
//   blk_valid  out  1              blk_out / blk_row / blk_col valid
//   blk_ready  in   1              downstream accepts tile
//   blk_row    out  16             tile row index, 0..IMG_H/BLK-1
//   blk_col    out  16             tile column index, 0..IMG_W/BLK-1
//   frame_done out  1              1-cycle pulse after the last tile of a frame is taken
// BEHAVIOUR
//   - Reset: blk_out=0, blk_valid=0, blk_row=0, blk_col=0, frame_done=0.
//     Both banks EMPTY, all counters 0. pix_ready=0 while rst=1.
//   - Reset mid-operation discards all buffered pixels and any held tile.
//     The next accepted pixel is (0,0) of a new frame.
//   - Band bank state is EMPTY or FULL.
//     pix_ready = !rst && bank[wr_bank]==EMPTY (combinational).
//   - Write side: a pixel is accepted on a posedge with pix_valid && pix_ready.
//     It is stored at bank[wr_bank][wr_y][wr_x], then wr_x increments.
//     When wr_x wraps from IMG_W-1, wr_y increments. Pixel values are not modified.
//   - When the pixel at wr_x=IMG_W-1, wr_y=BLK-1 is accepted, on that same edge:
//     wr_bank is set FULL, wr_bank toggles, wr_x=wr_y=0.
//   - Read side: the output register is "free" when blk_valid=0 or blk_ready=1.
//     When it is free and bank[rd_bank] is FULL, the tile at rd_col is loaded:
//     element (r,c) = bank[rd_bank][r][rd_col*BLK+c].
//     At the same time blk_row=band, blk_col=rd_col, blk_valid=1.
//   - If the output register is free and no FULL bank exists, blk_valid goes to 0.
//   - While blk_valid=1 && blk_ready=0, blk_out, blk_row and blk_col hold stable.
//   - Throughput is one tile per cycle with blk_ready held at 1 (handshake and reload
//     happen on the same edge).
//   - Latency: last band pixel accepted at edge t -> bank FULL after t.
//     First tile is loaded at edge t+1, so blk_valid=1 during the cycle after t+1.
//   - Loading tile rd_col=IMG_W/BLK-1 does all of the following on that edge:
//     marks bank[rd_bank] EMPTY, toggles rd_bank, resets rd_col to 0, increments band.
//     pix_ready for that bank can rise in the next cycle.
//   - Simultaneous events: a write completing a band and a read freeing the other bank
//     on the same edge are both applied. No pixel is lost or duplicated.
//   - Frame end: the handshake of tile (IMG_H/BLK-1, IMG_W/BLK-1) at edge e raises
//     frame_done for exactly the cycle after e. band wraps to 0. Back-to-back frames
//     need no idle cycle.
//   - Write-side band counting wraps at IMG_H/BLK independently of the read side.
// TESTING
//   1. Hold rst for 3 cycles -> blk_valid=0, frame_done=0, pix_ready=0.
//      Cycle after release -> pix_ready=1.
//   2. Ramp frame pix=(y*128+x) mod 2^16, pix_valid=1, blk_ready=1 -> tile (0,0)
//      element (r,c)=r*128+c; tile (0,1) element 0 = 8.
//      Expect 256 tiles in raster order and exactly one frame_done.
//   3. blk_ready=0 throughout -> first tile is held unchanged.
//      pix_ready drops after exactly 2048 accepted pixels (both banks FULL).
//   4. Random blk_ready (50%) and random pix_valid gaps over 2 frames -> each tile is
//      emitted once, in order, with correct contents. frame_done pulses twice.
//   5. Assert rst after 500 pixels, then send a full ramp frame -> no tile appears
//      before the reset. The first tile after reset is (0,0) with element 0 = 0.
//   6. IMG_W=16, IMG_H=16, BLK=4; pixels alternate -32768 / 32767 -> signed values pass
//      unchanged; 16 tiles, blk_col cycles 0..3.

Source files
------------

// File: rtl/block_tiler.sv
// Raster-to-tile converter: fills BLK-row bands into two ping-pong banks and
// drains each full band as BLK x BLK tiles in block-raster order.
module block_tiler #(
    parameter int N     = 16,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int BLK   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [N*BLK*BLK-1:0]   blk_out,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [15:0]            blk_row,
    output logic [15:0]            blk_col,
    output logic                   frame_done
);

    localparam int TILES_X = IMG_W / BLK;
    localparam int TILES_Y = IMG_H / BLK;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int CW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int BW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

    logic [N-1:0]         band_mem [2][BLK][IMG_W];
    logic [XW-1:0]        wr_x_reg;
    logic [YW-1:0]        wr_y_reg;
    logic                 wr_bank_reg;
    logic [1:0]           full_reg;
    logic                 rd_bank_reg;
    logic [CW-1:0]        rd_col_reg;
    logic [BW-1:0]        band_reg;
    logic [N*BLK*BLK-1:0] tile_next;

    logic wr_fire, wr_last, out_free, rd_fire, rd_last, take_last;

    assign pix_ready = !rst && !full_reg[wr_bank_reg];
    assign wr_fire   = pix_valid && pix_ready;
    assign wr_last   = wr_fire && (wr_x_reg == XW'(IMG_W - 1)) && (wr_y_reg == YW'(BLK - 1));
    assign out_free  = !blk_valid || blk_ready;
    assign rd_fire   = out_free && full_reg[rd_bank_reg];
    assign rd_last   = rd_fire && (rd_col_reg == CW'(TILES_X - 1));
    assign take_last = blk_valid && blk_ready &&
                       (blk_row == 16'(TILES_Y - 1)) && (blk_col == 16'(TILES_X - 1));

    // Band storage has no reset; the FULL/EMPTY flags alone decide what is live.
    always_ff @(posedge clk) begin
        if (wr_fire)
            band_mem[wr_bank_reg][wr_y_reg][wr_x_reg] <= pix_in;
    end

    // Whole tile is gathered combinationally from the bank being drained.
    genvar gi, gj;
    generate
        for (gi = 0; gi < BLK; gi++) begin : g_row
            for (gj = 0; gj < BLK; gj++) begin : g_col
                logic [XW-1:0] src_x;
                assign src_x = XW'(rd_col_reg * BLK + gj);
                assign tile_next[(gi*BLK+gj)*N +: N] = band_mem[rd_bank_reg][gi][src_x];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_x_reg    <= '0;
            wr_y_reg    <= '0;
            wr_bank_reg <= 1'b0;
        end else if (wr_fire) begin
            if (wr_x_reg == XW'(IMG_W - 1)) begin
                wr_x_reg <= '0;
                if (wr_y_reg == YW'(BLK - 1)) begin
                    wr_y_reg    <= '0;
                    wr_bank_reg <= !wr_bank_reg;
                end else begin
                    wr_y_reg <= wr_y_reg + 1'b1;
                end
            end else begin
                wr_x_reg <= wr_x_reg + 1'b1;
            end
        end
    end

    // Filling and draining always target different banks, so both updates can land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= '0;
        end else begin
            if (wr_last)
                full_reg[wr_bank_reg] <= 1'b1;
            if (rd_last)
                full_reg[rd_bank_reg] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank_reg <= 1'b0;
            rd_col_reg  <= '0;
            band_reg    <= '0;
            blk_out     <= '0;
            blk_valid   <= 1'b0;
            blk_row     <= '0;
            blk_col     <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= take_last;
            if (rd_fire) begin
                blk_out   <= tile_next;
                blk_valid <= 1'b1;
                blk_row   <= 16'(band_reg);
                blk_col   <= 16'(rd_col_reg);
                if (rd_last) begin
                    rd_col_reg  <= '0;
                    rd_bank_reg <= !rd_bank_reg;
                    band_reg    <= (band_reg == BW'(TILES_Y - 1)) ? '0 : band_reg + 1'b1;
                end else begin
                    rd_col_reg <= rd_col_reg + 1'b1;
                end
            end else if (out_free) begin
                blk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_block_tiler.sv
// Bench for block_tiler: 128x128/8 instance against a pixel-log reference model,
// plus a 16x16/4 instance carrying extreme signed values.
module tb_block_tiler;

    logic          clk = 1'b0;
    logic          rst, pix_valid, pix_ready, blk_valid, blk_ready, frame_done;
    logic [15:0]   pix_in, blk_row, blk_col;
    logic [1023:0] blk_out;

    logic          s_rst, s_pix_valid, s_pix_ready, s_blk_valid, s_blk_ready, s_frame_done;
    logic [15:0]   s_pix_in, s_blk_row, s_blk_col;
    logic [255:0]  s_blk_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    block_tiler #(.N(16), .IMG_W(128), .IMG_H(128), .BLK(8)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_row(blk_row), .blk_col(blk_col), .frame_done(frame_done));

    block_tiler #(.N(16), .IMG_W(16), .IMG_H(16), .BLK(4)) dut_small (
        .clk(clk), .rst(s_rst), .pix_in(s_pix_in), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .blk_out(s_blk_out), .blk_valid(s_blk_valid), .blk_ready(s_blk_ready),
        .blk_row(s_blk_row), .blk_col(s_blk_col), .frame_done(s_frame_done));

    task automatic report(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", msg);
        end
    endtask

    // ---------------- reference model: log of every accepted pixel since reset
    logic [15:0]   pix_log[$];
    logic [1023:0] cap[256];
    int  tiles_rx = 0;
    int  fd_count = 0;
    int  valid_seen = 0;
    bit  fd_pend = 1'b0;
    bit  cap_on = 1'b0;
    int  rdy_mode = 0;

    task automatic check_tile();
        int k, f, t, br, bc, base, bad;
        k  = tiles_rx;
        f  = k / 256;
        t  = k % 256;
        br = t / 16;
        bc = t % 16;
        base = f*16384 + br*1024 + bc*8;
        if (base + 7*128 + 7 >= pix_log.size()) begin
            report(1'b0, $sformatf("tile_early k=%0d needs pixel %0d, only %0d accepted",
                                   k, base + 7*128 + 7, pix_log.size()));
        end else begin
            report(blk_row == 16'(br) && blk_col == 16'(bc),
                   $sformatf("tile_pos k=%0d got (%0d,%0d) expected (%0d,%0d)",
                             k, blk_row, blk_col, br, bc));
            bad = -1;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (bad < 0 && blk_out[(r*8+c)*16 +: 16] !== pix_log[base + r*128 + c])
                        bad = r*8 + c;
            if (bad < 0)
                report(1'b1, "tile_data");
            else
                report(1'b0, $sformatf("tile_data k=%0d elem %0d got %h expected %h", k, bad,
                       blk_out[bad*16 +: 16], pix_log[base + (bad/8)*128 + (bad%8)]));
        end
        if (cap_on && f == 0)
            cap[t] = blk_out;
        if (t == 255)
            fd_pend = 1'b1;
        tiles_rx++;
    endtask

    // Monitor on the falling edge: whatever handshakes are visible now happen at the next rise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pix_log.delete();
                tiles_rx = 0;
                fd_pend  = 1'b0;
            end else begin
                if (frame_done || fd_pend)
                    report(frame_done == fd_pend,
                           $sformatf("frame_done got %0b expected %0b", frame_done, fd_pend));
                if (frame_done)
                    fd_count++;
                fd_pend = 1'b0;
                if (blk_valid)
                    valid_seen++;
                if (blk_valid && blk_ready)
                    check_tile();
                if (pix_valid && pix_ready)
                    pix_log.push_back(pix_in);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       blk_ready = 1'b0;
                1:       blk_ready = 1'b1;
                default: blk_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // kind 0: ramp value = pixel index within the call; kind 1: random values
    task automatic send_pix(input int npix, input int kind, input int pct, input int max_cyc,
                            output int sent);
        int cyc = 0;
        sent = 0;
        while (sent < npix && cyc < max_cyc) begin
            pix_valid = ($urandom_range(99) < pct);
            pix_in    = (kind == 0) ? 16'(sent % 16384) : 16'($urandom);
            @(negedge clk);
            if (pix_valid && pix_ready)
                sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        pix_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_tiles(input int target, input int max_cyc);
        int cyc = 0;
        while (tiles_rx < target && cyc < max_cyc) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        report(tiles_rx == target, $sformatf("tile_count got %0d expected %0d", tiles_rx, target));
    endtask

    typedef struct {
        int          br;
        int          bc;
        int          r;
        int          c;
        logic [15:0] exp;
    } vec_t;

    bit small_done = 1'b0;

    initial begin
        vec_t          vecs[8];
        int            sent, fd0, vs0;
        logic [1023:0] ev, held, tv;

        vecs[0] = '{0, 0, 0, 0, 16'd0};
        vecs[1] = '{0, 0, 1, 0, 16'd128};
        vecs[2] = '{0, 0, 7, 7, 16'd903};
        vecs[3] = '{0, 1, 0, 0, 16'd8};
        vecs[4] = '{0, 15, 0, 7, 16'd127};
        vecs[5] = '{1, 0, 0, 0, 16'd1024};
        vecs[6] = '{8, 3, 2, 5, 16'd8477};
        vecs[7] = '{15, 15, 7, 7, 16'd16383};

        rst = 1'b1;
        pix_valid = 1'b0;
        pix_in = '0;
        blk_ready = 1'b0;

        // reset state
        repeat (3) begin
            @(negedge clk);
            report(blk_valid == 1'b0 && frame_done == 1'b0 && pix_ready == 1'b0,
                   $sformatf("reset_state valid=%0b done=%0b ready=%0b expected 0/0/0",
                             blk_valid, frame_done, pix_ready));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        report(pix_ready == 1'b1, $sformatf("ready_after_reset got %0b expected 1", pix_ready));
        @(posedge clk);
        #1;

        // ramp frame, free-flowing output
        rdy_mode = 1;
        cap_on = 1'b1;
        fd0 = fd_count;
        send_pix(16384, 0, 100, 20000, sent);
        report(sent == 16384, $sformatf("ramp_send got %0d expected 16384", sent));
        wait_tiles(256, 2000);
        report(fd_count - fd0 == 1, $sformatf("ramp_frame_done got %0d expected 1", fd_count - fd0));
        cap_on = 1'b0;
        foreach (vecs[i]) begin
            tv = cap[vecs[i].br*16 + vecs[i].bc];
            report(tv[(vecs[i].r*8 + vecs[i].c)*16 +: 16] == vecs[i].exp,
                   $sformatf("ramp_elem tile(%0d,%0d) (%0d,%0d) got %0d expected %0d",
                             vecs[i].br, vecs[i].bc, vecs[i].r, vecs[i].c,
                             tv[(vecs[i].r*8 + vecs[i].c)*16 +: 16], vecs[i].exp));
        end

        // downstream stalled: both banks fill, first tile holds
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_pix(2100, 0, 100, 2400, sent);
        report(sent == 2048, $sformatf("stall_accepted got %0d expected 2048", sent));
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                ev[(r*8+c)*16 +: 16] = 16'(r*128 + c);
        report(blk_valid == 1'b1 && blk_row == 16'd0 && blk_col == 16'd0,
               $sformatf("stall_head valid=%0b tile=(%0d,%0d) expected 1 (0,0)", blk_valid, blk_row, blk_col));
        report(blk_out == ev, $sformatf("stall_tile elem0 got %0d expected 0", blk_out[15:0]));
        held = blk_out;
        repeat (6) begin
            @(negedge clk);
            report(blk_out == held && blk_valid == 1'b1 && blk_row == 16'd0 && blk_col == 16'd0
                   && pix_ready == 1'b0,
                   $sformatf("stall_hold valid=%0b ready=%0b row=%0d col=%0d elem1=%0d expected 1 0 0 0 1",
                             blk_valid, pix_ready, blk_row, blk_col, blk_out[31:16]));
        end
        @(posedge clk);
        #1;

        // mid-frame reset: partial band produces nothing, fresh frame starts at (0,0)
        do_reset(2);
        rdy_mode = 1;
        vs0 = valid_seen;
        send_pix(500, 0, 100, 600, sent);
        repeat (3) @(posedge clk);
        #1;
        report(valid_seen == vs0, $sformatf("pre_reset_tiles got %0d expected 0", valid_seen - vs0));
        do_reset(2);
        cap[0] = '1;
        cap_on = 1'b1;
        fd0 = fd_count;
        send_pix(16384, 0, 100, 20000, sent);
        wait_tiles(256, 2000);
        cap_on = 1'b0;
        report(cap[0][15:0] == 16'd0, $sformatf("first_after_reset elem0 got %0d expected 0", cap[0][15:0]));
        report(fd_count - fd0 == 1, $sformatf("reset_frame_done got %0d expected 1", fd_count - fd0));

        // two random frames with input gaps and random backpressure
        rdy_mode = 2;
        fd0 = fd_count;
        send_pix(32768, 1, 75, 60000, sent);
        report(sent == 32768, $sformatf("random_send got %0d expected 32768", sent));
        wait_tiles(768, 4000);
        report(fd_count - fd0 == 2, $sformatf("random_frame_done got %0d expected 2", fd_count - fd0));

        for (int i = 0; i < 200 && !small_done; i++)
            @(posedge clk);
        report(small_done == 1'b1, "small_instance_timeout got 0 expected 1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- 16x16 image, 4x4 tiles, alternating extreme values
    int s_tiles = 0;
    int s_fd = 0;

    initial begin
        int sent, cyc;
        s_rst = 1'b1;
        s_pix_valid = 1'b0;
        s_pix_in = '0;
        s_blk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_rst = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < 256 && cyc < 2000) begin
            s_pix_in = (sent % 2 == 0) ? 16'h8000 : 16'h7fff;
            s_pix_valid = 1'b1;
            @(negedge clk);
            if (s_pix_ready)
                sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_pix_valid = 1'b0;
        report(sent == 256, $sformatf("small_send got %0d expected 256", sent));
        cyc = 0;
        while (s_tiles < 16 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        report(s_tiles == 16, $sformatf("small_tiles got %0d expected 16", s_tiles));
        report(s_fd == 1, $sformatf("small_frame_done got %0d expected 1", s_fd));
        small_done = 1'b1;
    end

    initial begin
        logic [255:0] sev;
        for (int e = 0; e < 16; e++)
            sev[e*16 +: 16] = (e % 2 == 0) ? 16'h8000 : 16'h7fff;
        forever begin
            @(negedge clk);
            if (!s_rst) begin
                if (s_frame_done)
                    s_fd++;
                if (s_blk_valid && s_blk_ready) begin
                    report(s_blk_row == 16'(s_tiles / 4) && s_blk_col == 16'(s_tiles % 4),
                           $sformatf("small_pos k=%0d got (%0d,%0d) expected (%0d,%0d)",
                                     s_tiles, s_blk_row, s_blk_col, s_tiles / 4, s_tiles % 4));
                    report(s_blk_out == sev,
                           $sformatf("small_data k=%0d elem0=%h elem1=%h expected 8000 7fff",
                                     s_tiles, s_blk_out[15:0], s_blk_out[31:16]));
                    s_tiles++;
                end
            end
        end
    end

endmodule
